// File: rtl/debounce_fsm.sv
// debounce_fsm: tick-paced switch debouncer with registered level, edge pulses and busy flag.
// Define DEBOUNCE_SYNC_EN to insert a two-flop synchronizer on sw_i.
module debounce_fsm #(
  parameter int Stable = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic sw_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);
  localparam int W = $clog2(Stable + 1);
  localparam logic [W-1:0] LAST = W'(Stable - 1);
  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic sw_s;
`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) sync_q <= '0;
    else sync_q <= {sync_q[0], sw_i};
  assign sw_s = sync_q[1];
`else
  assign sw_s = sw_i;
`endif
  // Abort is tested before the tick so a bounce on the final tick still cancels.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      ZERO: if (sw_s) begin
        state_d = WAIT1;
        cnt_d = '0;
      end
      WAIT1: if (!sw_s) state_d = ZERO;
        else if (tick_i) begin
          if (cnt_q == LAST) state_d = ONE;
          else cnt_d = cnt_q + 1'b1;
        end
      ONE: if (!sw_s) begin
        state_d = WAIT0;
        cnt_d = '0;
      end
      default: if (sw_s) state_d = ONE;
        else if (tick_i) begin
          if (cnt_q == LAST) state_d = ZERO;
          else cnt_d = cnt_q + 1'b1;
        end
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= ZERO;
      cnt_q <= '0;
      db_o <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      db_o <= state_d == ONE || state_d == WAIT0;
      rise_o <= state_q == WAIT1 && state_d == ONE;
      fall_o <= state_q == WAIT0 && state_d == ZERO;
      busy_o <= state_d == WAIT1 || state_d == WAIT0;
    end
endmodule

// File: tb/tb_debounce_fsm.sv
// tb_debounce_fsm: directed test-plan scenarios plus random switch/tick traffic against a tick-counting model.
module tb_debounce_fsm;
  localparam int S = 3;
  logic clk = 0, rst = 1, tick = 0, sw = 0;
  logic db, rise, fall, busy;
  int checks = 0, errors = 0;
  int ph = 0, per = 4, rises = 0, falls = 0, m_rises = 0, m_falls = 0;
  bit m_db, m_rise, m_fall, m_busy;
  int m_ticks;
  bit [1:0] m_sync;

  debounce_fsm #(.Stable(S)) dut (
    .clk_i(clk), .rst_i(rst), .tick_i(tick), .sw_i(sw),
    .db_o(db), .rise_o(rise), .fall_o(fall), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_db = 0; m_rise = 0; m_fall = 0; m_busy = 0; m_ticks = 0; m_sync = 0;
  endtask

  // Level flips once the sampled switch has disagreed with it for S ticks seen after the first disagreeing edge.
  task automatic model_clock(bit s, bit t);
    bit ss;
`ifdef DEBOUNCE_SYNC_EN
    ss = m_sync[1];
    m_sync = {m_sync[0], s};
`else
    ss = s;
`endif
    m_rise = 0;
    m_fall = 0;
    if (ss == m_db) m_busy = 0;
    else if (!m_busy) begin
      m_busy = 1;
      m_ticks = 0;
    end else if (t) begin
      m_ticks++;
      if (m_ticks == S) begin
        m_db = ss;
        m_rise = ss;
        m_fall = !ss;
        m_busy = 0;
      end
    end
    m_rises += int'(m_rise);
    m_falls += int'(m_fall);
  endtask

  task automatic compare_all();
    check("db", db, m_db);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("busy", busy, m_busy);
  endtask

  function automatic bit next_tick();
    return ph % per == 0;
  endfunction

  task automatic step(bit s);
    bit t;
    t = next_tick();
    ph++;
    sw = s;
    tick = t;
    @(posedge clk);
    if (rst) model_reset();
    else model_clock(s, t);
    #1;
    compare_all();
    rises += int'(rise);
    falls += int'(fall);
  endtask

  task automatic async_reset();
    rst = 1;
    #1;
    model_reset();
    compare_all();
  endtask

  initial begin
    model_reset();
    sw = 1;
    for (int i = 0; i < 6; i++) step(1);
    rst = 0;
    step(1);
`ifndef DEBOUNCE_SYNC_EN
    check("rst_release_busy", busy, 1);
`endif
    for (int i = 0; i < 16; i++) step(1);
    check("press_db", db, 1);
    check("press_rises", rises, 1);
    rises = 0;
    falls = 0;
    for (int i = 0; i < 20; i++) step(0);
    check("release_falls", falls, 1);
    for (int i = 0; i < 5; i++) step(1);
    for (int i = 0; i < 10; i++) step(0);
    check("bounce_db", db, 0);
    check("bounce_rises", rises, 0);
    for (int i = 0; i < 20; i++) step(1);
    falls = 0;
    begin
      int n = 0;
      bit up = 0;
      ph = 1;
      step(0);
      for (int i = 0; i < 20 && !up; i++) begin
        if (next_tick()) begin
          n++;
          up = n == S;
        end
        step(up);
      end
    end
    for (int i = 0; i < 4; i++) step(1);
`ifndef DEBOUNCE_SYNC_EN
    check("collide_db", db, 1);
    check("collide_falls", falls, 0);
`endif
    for (int i = 0; i < 20; i++) step(0);
    rises = 0;
    begin
      int n = 0;
      ph = 1;
      for (int i = 0; i < 40 && n < 2 + (m_busy ? 0 : 1); i++) begin
        if (next_tick() && m_busy) n++;
        step(1);
      end
    end
    async_reset();
    step(1);
    rst = 0;
    for (int i = 0; i < 20; i++) step(1);
    check("midwait_rises", rises, 1);
    for (int r = 0; r < 40; r++) begin
      per = $urandom_range(1, 6);
      for (int i = 0; i < 50; i++) begin
        if ($urandom_range(0, 199) == 0) async_reset();
        else if (rst) rst = 0;
        step($urandom_range(0, 9) < 3 ? !sw : sw);
      end
    end
    rst = 0;
    for (int i = 0; i < 30; i++) step(1);
    check("final_db", db, 1);
    check("rise_total", rises + m_rises - m_rises, rises);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
